ex: RTL

Execute stage of the five-stage MIPS pipeline: consumes the decoded operation and operands that the ID stage produces and computes the write-back value. It includes the HI/LO register pair, a single-cycle multiplier and a 32-iteration radix-2 divider that stalls the pipeline. Outputs are registered, so this block also forms the EX/MEM pipeline register.

---
 rtl/ex_if.sv | 25 ++
 rtl/ex.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_if.sv
// ID/EX operand bus into the MIPS execute stage and the registered EX/MEM results it returns.
interface ex_if;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex.sv
// MIPS execute stage: ALU, HI/LO pair, single-cycle multiplier and a stalling radix-2 divider.
// The output register doubles as the EX/MEM pipeline register.
module ex (
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  localparam logic [7:0] OP_AND   = 8'h24, OP_OR    = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C, OP_SRL   = 8'h02, OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h20, OP_ADDU  = 8'h21, OP_SUB  = 8'h22, OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A, OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MULT  = 8'h18, OP_MULTU = 8'h19, OP_DIV  = 8'h1A, OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_MFHI  = 8'h10, OP_MTHI  = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_e;

  divState_e   divState_q, divState_d;
  logic [4:0]  divCnt_q, divCnt_d;
  logic [31:0] divQuo_q, divQuo_d;
  logic [31:0] divRem_q, divRem_d;
  logic [31:0] divDvs_q, divDvs_d;
  logic        negQuo_q, negQuo_d;
  logic        negRem_q, negRem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] opA, opB, sum, diff, result;
  logic [63:0] mulA, mulB, prod;
  logic [32:0] divShift, divTrial;
  logic [31:0] remStep, quoStep;
  logic        isDiv, divSigned, isMul, ovf, stall;

  assign opA       = bus.reg1_i;
  assign opB       = bus.reg2_i;
  assign sum       = opA + opB;
  assign diff      = opA - opB;
  assign isDiv     = (bus.alusel_i == SEL_MUL) && ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU));
  assign divSigned = (bus.aluop_i == OP_DIV);
  assign isMul     = (bus.alusel_i == SEL_MUL) && ((bus.aluop_i == OP_MULT) || (bus.aluop_i == OP_MULTU));

  // One 64x64 multiplier serves both flavours; only the operand extension differs.
  assign mulA = (bus.aluop_i == OP_MULT) ? {{32{opA[31]}}, opA} : {32'b0, opA};
  assign mulB = (bus.aluop_i == OP_MULT) ? {{32{opB[31]}}, opB} : {32'b0, opB};
  assign prod = mulA * mulB;

  // Restoring step: the dividend shifts out of divQuo_q while quotient bits shift in.
  assign divShift = {divRem_q, divQuo_q[31]};
  assign divTrial = divShift - {1'b0, divDvs_q};
  assign remStep  = divTrial[32] ? divShift[31:0] : divTrial[31:0];
  assign quoStep  = {divQuo_q[30:0], ~divTrial[32]};

  always_comb begin
    divState_d = divState_q;
    divCnt_d   = divCnt_q;
    divQuo_d   = divQuo_q;
    divRem_d   = divRem_q;
    divDvs_d   = divDvs_q;
    negQuo_d   = negQuo_q;
    negRem_d   = negRem_q;
    stall      = 1'b0;
    case (divState_q)
      DIV_IDLE: begin
        if (isDiv) begin
          stall = 1'b1;
          if (opB == 32'd0) begin
            divState_d = DIV_DONE;
            divQuo_d   = '1;
            divRem_d   = opA;
          end else begin
            divState_d = DIV_BUSY;
            divCnt_d   = 5'd0;
            divQuo_d   = (divSigned && opA[31]) ? -opA : opA;
            divDvs_d   = (divSigned && opB[31]) ? -opB : opB;
            divRem_d   = '0;
            negQuo_d   = divSigned && (opA[31] ^ opB[31]);
            negRem_d   = divSigned && opA[31];
          end
        end
      end
      DIV_BUSY: begin
        stall    = 1'b1;
        divCnt_d = divCnt_q + 5'd1;
        divQuo_d = quoStep;
        divRem_d = remStep;
        if (divCnt_q == 5'd31) begin
          divState_d = DIV_DONE;
          divQuo_d   = negQuo_q ? -quoStep : quoStep;
          divRem_d   = negRem_q ? -remStep : remStep;
        end
      end
      DIV_DONE: divState_d = DIV_IDLE;
      default:  divState_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (bus.alusel_i)
      SEL_LOGIC: begin
        case (bus.aluop_i)
          OP_AND:  result = opA & opB;
          OP_OR:   result = opA | opB;
          OP_XOR:  result = opA ^ opB;
          OP_NOR:  result = ~(opA | opB);
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.aluop_i)
          OP_SLL:  result = opB << opA[4:0];
          OP_SRL:  result = opB >> opA[4:0];
          OP_SRA:  result = $unsigned($signed(opB) >>> opA[4:0]);
          default: result = '0;
        endcase
      end
      SEL_MOVE: begin
        case (bus.aluop_i)
          OP_MFHI: result = hi_q;
          OP_MFLO: result = lo_q;
          default: result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.aluop_i)
          OP_ADD: begin
            result = sum;
            ovf    = (opA[31] == opB[31]) && (sum[31] != opA[31]);
          end
          OP_ADDU: result = sum;
          OP_SUB: begin
            result = diff;
            ovf    = (opA[31] != opB[31]) && (diff[31] != opA[31]);
          end
          OP_SUBU: result = diff;
          OP_SLT:  result = {31'b0, ($signed(opA) < $signed(opB))};
          OP_SLTU: result = {31'b0, (opA < opB)};
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  // HI/LO update on the same edge as the output register, so MFHI/MFLO see the prior write.
  always_comb begin
    wd_d    = bus.wd_i;
    wreg_d  = bus.wreg_i & ~ovf;
    wdata_d = result;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (stall) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
    end else if (divState_q == DIV_DONE) begin
      hi_d = divRem_q;
      lo_d = divQuo_q;
    end else if (isMul) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end else if (bus.alusel_i == SEL_MOVE && bus.aluop_i == OP_MTHI) begin
      hi_d = opA;
    end else if (bus.alusel_i == SEL_MOVE && bus.aluop_i == OP_MTLO) begin
      lo_d = opA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divState_q <= DIV_IDLE;
      divCnt_q   <= '0;
      divQuo_q   <= '0;
      divRem_q   <= '0;
      divDvs_q   <= '0;
      negQuo_q   <= 1'b0;
      negRem_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      divState_q <= divState_d;
      divCnt_q   <= divCnt_d;
      divQuo_q   <= divQuo_d;
      divRem_q   <= divRem_d;
      divDvs_q   <= divDvs_d;
      negQuo_q   <= negQuo_d;
      negRem_q   <= negRem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.wd_o       = wd_q;
  assign bus.wreg_o     = wreg_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.stallreq_o = stall & ~rst;
endmodule
